// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
//   Shared definitions for the PS/2 keyboard event sequencer: prefix byte
//   values, field widths, FSM state encoding and the key-event record.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;  // extended-key prefix
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;  // break (release) prefix
    localparam int         PS2_CODE_W  = 8;      // scan-code width
    localparam int         PS2_KEY_W   = 9;      // {ext, code}

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_DECODE = 2'd2,
        ST_EMIT   = 2'd3
    } kbd_state_e;

    typedef struct packed {
        logic                  rel;   // 1 = release, 0 = press
        logic                  ext;   // event was E0-prefixed
        logic [PS2_CODE_W-1:0] code;  // scan code with prefixes stripped
    } kbd_evt_t;

endpackage

// File: rtl/ps2_pfx_timer.sv
// ps2_pfx_timer
//   Down-counter that bounds how long a dangling E0/F0 prefix may wait for
//   its scan code.
//   Ports:
//     clk, clrn  clock / asynchronous active-low reset
//     load_i     (re)start the countdown at TMO
//     clr_i      stop the countdown (prefix consumed)
//     expire_o   one-cycle pulse on the edge where the countdown runs out
module ps2_pfx_timer #(
    parameter int TMO = 4096
) (
    input  logic clk,
    input  logic clrn,
    input  logic load_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int W = $clog2(TMO + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Expiry fires on the edge that takes the count 1 -> 0, i.e. TMO edges
    // after the load edge. A load or clear on that same edge takes priority.
    assign expire_o = (cnt_q == W'(1)) && !load_i && !clr_i;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(TMO);
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl
//   Pops scan-code bytes from the ps2_keyboard FIFO, folds E0/F0 prefixes
//   into whole key events, filters typematic repeats of the held key and
//   presents events on a valid/ready port.
//   Ports:
//     clk, clrn                    clock / asynchronous active-low reset
//     kbd_data, kbd_ready          FIFO head byte / FIFO non-empty
//     kbd_overflow                 FIFO overflow flag
//     kbd_nextdata_n               active-low one-cycle pop strobe
//     evt_valid, evt_ready         event handshake
//     evt_code, evt_ext, evt_release  event fields
//     key_down, cur_code           held-key status, {ext,code} of held key
//     press_cnt                    wrapping count of emitted presses
//     ovf_sticky, ovf_clr          sticky overflow flag and its clear
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter bit REPEAT_EN = 1'b0,
    parameter int CNT_W     = 8,
    parameter int PFX_TMO   = 4096
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic [PS2_CODE_W-1:0] kbd_data,
    input  logic                  kbd_ready,
    input  logic                  kbd_overflow,
    output logic                  kbd_nextdata_n,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [PS2_CODE_W-1:0] evt_code,
    output logic                  evt_ext,
    output logic                  evt_release,
    output logic                  key_down,
    output logic [PS2_KEY_W-1:0]  cur_code,
    output logic [CNT_W-1:0]      press_cnt,
    output logic                  ovf_sticky,
    input  logic                  ovf_clr
);
    kbd_state_e            state_q, state_d;
    logic [PS2_CODE_W-1:0] byte_q, byte_d;
    logic                  ext_f_q, ext_f_d;
    logic                  brk_f_q, brk_f_d;
    logic                  nextdata_n_q, nextdata_n_d;
    logic                  evt_valid_q, evt_valid_d;
    kbd_evt_t              evt_q, evt_d;
    logic                  key_down_q, key_down_d;
    logic [PS2_KEY_W-1:0]  cur_code_q, cur_code_d;
    logic [CNT_W-1:0]      press_cnt_q, press_cnt_d;
    logic                  ovf_q, ovf_d;

    logic                  tmr_load, tmr_clr, tmr_expire;
    logic [PS2_KEY_W-1:0]  key_w;

    assign key_w = {ext_f_q, byte_q};

    ps2_pfx_timer #(.TMO(PFX_TMO)) u_pfx_timer (
        .clk      (clk),
        .clrn     (clrn),
        .load_i   (tmr_load),
        .clr_i    (tmr_clr),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        ext_f_d      = ext_f_q;
        brk_f_d      = brk_f_q;
        nextdata_n_d = 1'b1;
        evt_valid_d  = evt_valid_q;
        evt_d        = evt_q;
        key_down_d   = key_down_q;
        cur_code_d   = cur_code_q;
        press_cnt_d  = press_cnt_q;
        ovf_d        = ovf_q;
        tmr_load     = 1'b0;
        tmr_clr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // No pop while an event is still pending; the FIFO absorbs it.
                if (kbd_ready && !evt_valid_q) begin
                    byte_d       = kbd_data;
                    nextdata_n_d = 1'b0;
                    state_d      = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (byte_q == PS2_PFX_EXT) begin
                    ext_f_d  = 1'b1;
                    tmr_load = 1'b1;
                end else if (byte_q == PS2_PFX_BRK) begin
                    brk_f_d  = 1'b1;
                    tmr_load = 1'b1;
                end else begin
                    ext_f_d = 1'b0;
                    brk_f_d = 1'b0;
                    tmr_clr = 1'b0 | 1'b1;
                    if (brk_f_q) begin
                        evt_d       = '{rel: 1'b1, ext: ext_f_q, code: byte_q};
                        evt_valid_d = 1'b1;
                        state_d     = ST_EMIT;
                        // Releasing some other key leaves the held key alone.
                        if (key_w == cur_code_q) begin
                            key_down_d = 1'b0;
                        end
                    end else if (key_down_q && key_w == cur_code_q) begin
                        // Typematic repeat: optionally forwarded, never counted.
                        if (REPEAT_EN) begin
                            evt_d       = '{rel: 1'b0, ext: ext_f_q, code: byte_q};
                            evt_valid_d = 1'b1;
                            state_d     = ST_EMIT;
                        end
                    end else begin
                        evt_d       = '{rel: 1'b0, ext: ext_f_q, code: byte_q};
                        evt_valid_d = 1'b1;
                        state_d     = ST_EMIT;
                        cur_code_d  = key_w;
                        key_down_d  = 1'b1;
                        press_cnt_d = press_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stale prefix is dropped without producing an event.
        if (tmr_expire) begin
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
        end

        // Overflow invalidates any half-assembled prefix and wins over clear.
        if (kbd_overflow) begin
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
            ovf_d   = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= ST_IDLE;
            byte_q       <= '0;
            ext_f_q      <= 1'b0;
            brk_f_q      <= 1'b0;
            nextdata_n_q <= 1'b1;
            evt_valid_q  <= 1'b0;
            evt_q        <= '0;
            key_down_q   <= 1'b0;
            cur_code_q   <= '0;
            press_cnt_q  <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            ext_f_q      <= ext_f_d;
            brk_f_q      <= brk_f_d;
            nextdata_n_q <= nextdata_n_d;
            evt_valid_q  <= evt_valid_d;
            evt_q        <= evt_d;
            key_down_q   <= key_down_d;
            cur_code_q   <= cur_code_d;
            press_cnt_q  <= press_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign kbd_nextdata_n = nextdata_n_q;
    assign evt_valid      = evt_valid_q;
    assign evt_code       = evt_q.code;
    assign evt_ext        = evt_q.ext;
    assign evt_release    = evt_q.rel;
    assign key_down       = key_down_q;
    assign cur_code       = cur_code_q;
    assign press_cnt      = press_cnt_q;
    assign ovf_sticky     = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl
//   Two controllers (REPEAT_EN=0 and REPEAT_EN=1) are fed identical byte
//   streams from two FIFO models. A byte-stream key model predicts the
//   events of each and a scoreboard compares them on every handshake.
module tb_ps2_kbd_ctrl;

    localparam int TB_CNT_W = 4;
    localparam int TB_TMO   = 4096;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic kbd_overflow = 1'b0;
    logic evt_ready = 1'b0;
    logic ovf_clr = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]          kbd_data   [2];
    logic                kbd_ready  [2];
    logic                nextdata_n [2];
    logic                evt_valid  [2];
    logic [7:0]          evt_code   [2];
    logic                evt_ext    [2];
    logic                evt_rel    [2];
    logic                key_down   [2];
    logic [8:0]          cur_code   [2];
    logic [TB_CNT_W-1:0] press_cnt  [2];
    logic                ovf_sticky [2];

    // FIFO models: written by the main process, popped on the strobe.
    logic [7:0] fifo_mem [2][256];
    int         fifo_wr  [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            int rd_ptr = 0;
            assign kbd_ready[gi] = (rd_ptr != fifo_wr[gi]);
            assign kbd_data[gi]  = fifo_mem[gi][rd_ptr[7:0]];
            always @(posedge clk) begin
                if (!nextdata_n[gi] && kbd_ready[gi]) rd_ptr <= rd_ptr + 1;
            end

            ps2_kbd_ctrl #(
                .REPEAT_EN (gi == 1),
                .CNT_W     (TB_CNT_W),
                .PFX_TMO   (TB_TMO)
            ) u_dut (
                .clk            (clk),
                .clrn           (clrn),
                .kbd_data       (kbd_data[gi]),
                .kbd_ready      (kbd_ready[gi]),
                .kbd_overflow   (kbd_overflow),
                .kbd_nextdata_n (nextdata_n[gi]),
                .evt_valid      (evt_valid[gi]),
                .evt_ready      (evt_ready),
                .evt_code       (evt_code[gi]),
                .evt_ext        (evt_ext[gi]),
                .evt_release    (evt_rel[gi]),
                .key_down       (key_down[gi]),
                .cur_code       (cur_code[gi]),
                .press_cnt      (press_cnt[gi]),
                .ovf_sticky     (ovf_sticky[gi]),
                .ovf_clr        (ovf_clr)
            );
        end
    endgenerate

    // Reference key model ({rel,ext,code} events)
    logic       m_ext  [2];
    logic       m_brk  [2];
    logic       m_down [2];
    logic [8:0] m_cur  [2];
    int         m_cnt  [2];
    logic [9:0] exp_q0 [$];
    logic [9:0] exp_q1 [$];

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_mode = 1;   // 0: evt_ready low, 1: high, 2: random

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic exp_push(input int k, input logic [9:0] ev);
        if (k == 0) exp_q0.push_back(ev);
        else        exp_q1.push_back(ev);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ext[k] = 1'b0; m_brk[k] = 1'b0; m_down[k] = 1'b0;
            m_cur[k] = 9'h0; m_cnt[k] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_flush();
        for (int k = 0; k < 2; k++) begin
            m_ext[k] = 1'b0; m_brk[k] = 1'b0;
        end
    endtask

    task automatic model_byte(input int k, input logic [7:0] b);
        logic [8:0] key;
        if (b == 8'hE0) begin
            m_ext[k] = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk[k] = 1'b1;
        end else begin
            key = {m_ext[k], b};
            if (m_brk[k]) begin
                exp_push(k, {1'b1, key});
                if (key == m_cur[k]) m_down[k] = 1'b0;
            end else if (m_down[k] && key == m_cur[k]) begin
                if (k == 1) exp_push(k, {1'b0, key});
            end else begin
                exp_push(k, {1'b0, key});
                m_cur[k]  = key;
                m_down[k] = 1'b1;
                m_cnt[k]  = m_cnt[k] + 1;
            end
            m_ext[k] = 1'b0;
            m_brk[k] = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] b);
        for (int k = 0; k < 2; k++) begin
            fifo_mem[k][fifo_wr[k][7:0]] = b;
            fifo_wr[k] = fifo_wr[k] + 1;
            model_byte(k, b);
        end
    endtask

    // One clock: drive evt_ready after the edge, then score handshakes at negedge.
    task automatic tick();
        logic [9:0] got, exp;
        logic       have;
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       evt_ready = 1'b0;
            1:       evt_ready = 1'b1;
            default: evt_ready = ($urandom_range(0, 3) != 0);
        endcase
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (clrn && evt_valid[k] && evt_ready) begin
                got  = {evt_rel[k], evt_ext[k], evt_code[k]};
                exp  = 10'h0;
                have = (k == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                if (have) exp = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                $display("[TB] dut%0d evt rel=%0b ext=%0b code=%02h", k, got[9], got[8], got[7:0]);
                check($sformatf("evt%0d_expected", k), 32'(have), 32'd1);
                check($sformatf("evt%0d_fields", k), 32'(got), 32'(exp));
            end
        end
    endtask

    task automatic wait_idle();
        int quiet, n;
        quiet = 0;
        n = 0;
        while (quiet < 6 && n < 3000) begin
            tick();
            n++;
            if (!kbd_ready[0] && !kbd_ready[1] && !evt_valid[0] && !evt_valid[1]) quiet++;
            else quiet = 0;
        end
        check("idle_reached", 32'(quiet >= 6), 32'd1);
        check("exp0_drained", 32'(exp_q0.size()), 32'd0);
        check("exp1_drained", 32'(exp_q1.size()), 32'd0);
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_keydown%0d", tag, k), 32'(key_down[k]), 32'(m_down[k]));
            check($sformatf("%s_curcode%0d", tag, k), 32'(cur_code[k]), 32'(m_cur[k]));
            check($sformatf("%s_presscnt%0d", tag, k), 32'(press_cnt[k]),
                  32'(m_cnt[k] % (1 << TB_CNT_W)));
        end
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_outs%0d", tag, k),
                  32'({nextdata_n[k], evt_valid[k], evt_ext[k], evt_rel[k], key_down[k],
                       ovf_sticky[k], evt_code[k], cur_code[k], press_cnt[k]}),
                  32'({1'b1, 26'h0}));
        end
    endtask

    logic [7:0] codes [6];
    logic [9:0] snap  [2];
    int         n, r;
    logic       e, rl, ord;
    logic [7:0] c;

    initial begin
        codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h75, 8'h6B};
        fifo_wr[0] = 0;
        fifo_wr[1] = 0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        clrn = 1'b1;
        rdy_mode = 1;

        // Press then release of 1C
        push(8'h1C);
        wait_idle();
        check_state("press1c");
        push(8'hF0); push(8'h1C);
        wait_idle();
        check_state("rel1c");

        // Typematic repeats of 1B
        push(8'h1B); push(8'h1B); push(8'h1B); push(8'hF0); push(8'h1B);
        wait_idle();
        check_state("repeat1b");

        // Extended key, both prefix orders on release
        push(8'hE0); push(8'h75);
        wait_idle();
        check_state("ext75_held");
        push(8'hE0); push(8'hF0); push(8'h75);
        wait_idle();
        check_state("ext75_rel1");
        push(8'hE0); push(8'h75); push(8'hF0); push(8'hE0); push(8'h75);
        wait_idle();
        check_state("ext75_rel2");

        // Backpressure: event held stable, no pops while pending
        rdy_mode = 0;
        tick();
        push(8'h2A); push(8'h2B); push(8'h2C);
        n = 0;
        while (!(evt_valid[0] && evt_valid[1]) && n < 100) begin tick(); n++; end
        check("bp_valid_seen", 32'(evt_valid[0] && evt_valid[1]), 32'd1);
        for (int k = 0; k < 2; k++) snap[k] = {evt_rel[k], evt_ext[k], evt_code[k]};
        repeat (20) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("bp_hold%0d", k),
                      32'({evt_valid[k], evt_rel[k], evt_ext[k], evt_code[k]}), 32'({1'b1, snap[k]}));
                check($sformatf("bp_nopop%0d", k), 32'({nextdata_n[k], kbd_ready[k]}), 32'd3);
            end
        end
        rdy_mode = 1;
        wait_idle();
        check_state("bp_drain");

        // Prefix timeout: stale F0 dropped, fresh F0 still honoured
        push(8'hF0);
        wait_idle();
        repeat (TB_TMO + 1) tick();
        model_flush();
        push(8'h1C);
        wait_idle();
        check_state("tmo_press");
        push(8'hF0);
        wait_idle();
        repeat (50) tick();
        push(8'h1C);
        wait_idle();
        check_state("tmo_short");

        // Random prefix/code streams with random consumer stalls
        rdy_mode = 2;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 25; i++) begin
                r = int'($urandom_range(0, 9));
                c = codes[$urandom_range(0, 5)];
                if (r == 0) begin
                    push(($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0);
                end else begin
                    e   = ($urandom_range(0, 1) != 0);
                    rl  = ($urandom_range(0, 2) == 0);
                    ord = ($urandom_range(0, 1) != 0);
                    if (ord && rl) push(8'hF0);
                    if (e) push(8'hE0);
                    if (!ord && rl) push(8'hF0);
                    push(c);
                end
                repeat ($urandom_range(0, 6)) tick();
            end
            wait_idle();
            check_state("rand");
        end
        rdy_mode = 1;

        // Overflow clears a pending prefix and sets the sticky flag
        push(8'hE0);
        wait_idle();
        kbd_overflow = 1'b1;
        tick();
        kbd_overflow = 1'b0;
        model_flush();
        for (int k = 0; k < 2; k++) check($sformatf("ovf_set%0d", k), 32'(ovf_sticky[k]), 32'd1);
        push(8'h4A);
        wait_idle();
        check_state("ovf_nopfx");
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        for (int k = 0; k < 2; k++) check($sformatf("ovf_clr%0d", k), 32'(ovf_sticky[k]), 32'd0);
        kbd_overflow = 1'b1; ovf_clr = 1'b1;
        tick();
        kbd_overflow = 1'b0; ovf_clr = 1'b0;
        for (int k = 0; k < 2; k++) check($sformatf("ovf_wins%0d", k), 32'(ovf_sticky[k]), 32'd1);

        // Overflow leaves a pending event alone; reset mid-EMIT clears all
        rdy_mode = 0;
        tick();
        push(8'h33);
        n = 0;
        while (!(evt_valid[0] && evt_valid[1]) && n < 100) begin tick(); n++; end
        kbd_overflow = 1'b1;
        tick();
        kbd_overflow = 1'b0;
        for (int k = 0; k < 2; k++)
            check($sformatf("ovf_pending%0d", k),
                  32'({evt_valid[k], evt_rel[k], evt_ext[k], evt_code[k], key_down[k]}),
                  32'({1'b1, 1'b0, 1'b0, 8'h33, 1'b1}));
        clrn = 1'b0;
        #1;
        check_reset("reset_emit");
        model_reset();
        tick();
        tick();
        clrn = 1'b1;
        rdy_mode = 1;
        push(8'h1C);
        wait_idle();
        check_state("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
